// File: rtl/div_sequencer_pkg.sv
// Shared constants for the divide sequencer: widths, op codes, FSM states, divider step counts.
// No logic; imported by div_sequencer and uint_diver.
// No backpressure; constants only.
package div_sequencer_pkg;

    localparam int DATAWIDTH      = 32;
    localparam int DIV_STEPS      = DATAWIDTH;
    localparam int DIV_STEPS_LOG2 = $clog2(DIV_STEPS);

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/div_sequencer_uint_diver.sv
// Unsigned restoring divider, one quotient bit per enabled cycle.
// Latency: STEPS enabled cycles after load; end_flag rises with the last step.
// Backpressure: en low freezes the iteration; load restarts it.
module uint_diver
    import div_sequencer_pkg::*;
#(
    parameter int STEPS = DIV_STEPS,
    parameter int CNT_W = DIV_STEPS_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [STEPS-1:0] dividend,
    input  logic [STEPS-1:0] divisor,
    output logic [STEPS-1:0] quotient,
    output logic [STEPS-1:0] remainder,
    output logic             end_flag
);

    logic [STEPS-1:0] rem_q;
    logic [STEPS-1:0] quo_q;
    logic [STEPS-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [STEPS:0]   trial;
    logic             ge;

    assign trial = {rem_q, quo_q[STEPS-1]};
    assign ge    = (trial >= {1'b0, dvs_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            end_flag <= 1'b0;
        end else if (load) begin
            rem_q    <= '0;
            quo_q    <= dividend;
            dvs_q    <= divisor;
            cnt_q    <= '0;
            end_flag <= 1'b0;
        end else if (en && !end_flag) begin
            // a zero divisor always "fits": quotient fills with ones, remainder rebuilds the dividend
            rem_q <= ge ? (trial[STEPS-1:0] - dvs_q) : trial[STEPS-1:0];
            quo_q <= {quo_q[STEPS-2:0], ge};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(STEPS - 1))
                end_flag <= 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_sequencer.sv
// Signed/unsigned DIV/REM sequencer around uint_diver; optional macro DIV_FASTPATH_EN.
// Latency: done 36 cycles after start accept (3 for zero divisor / overflow with DIV_FASTPATH_EN).
// Backpressure: busy stalls the pipe; start outside IDLE is dropped; flush aborts to IDLE.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_W = DATAWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              div_by_zero
);

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state, nxt;
    logic [1:0]        op_q;
    logic              sa_q, sb_q, dbz_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              is_signed, is_rem, neg_a, neg_b, ovf;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic              div_load, div_en, div_end;
    logic [DATA_W-1:0] div_quo, div_rem;
    logic [DATA_W-1:0] q_fix, r_fix;

    assign is_signed = (op_q == OP_DIV) || (op_q == OP_REM);
    assign is_rem    = (op_q == OP_REM) || (op_q == OP_REMU);
    assign neg_a     = is_signed & sa_q;
    assign neg_b     = is_signed & sb_q;
    assign ovf       = is_signed & (a_q == MIN_NEG) & (b_q == '1);
    assign mag_a     = neg_a ? -a_q : a_q;
    assign mag_b     = neg_b ? -b_q : b_q;

    assign div_load  = (state == S_PREP) & ~flush;
    assign div_en    = (state == S_RUN) & ~div_end & ~flush;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (start) nxt = S_PREP;
`ifdef DIV_FASTPATH_EN
            S_PREP: nxt = (dbz_q || ovf) ? S_POST : S_RUN;
`else
            S_PREP: nxt = S_RUN;
`endif
            S_RUN:  if (div_end) nxt = S_POST;
            S_POST: nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (flush)
            nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_DIV;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            dbz_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (state == S_IDLE && start && !flush) begin
            op_q  <= op;
            sa_q  <= src_a[DATA_W-1];
            sb_q  <= src_b[DATA_W-1];
            dbz_q <= (src_b == '0);
            a_q   <= src_a;
            b_q   <= src_b;
        end
    end

    // Special cases are forced explicitly so the fast path needs no divider output.
    always_comb begin
        q_fix = (neg_a ^ neg_b) ? -div_quo : div_quo;
        r_fix = neg_a ? -div_rem : div_rem;
        if (dbz_q) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (ovf) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (state == S_POST && !flush) begin
            result      <= is_rem ? r_fix : q_fix;
            div_by_zero <= dbz_q;
        end
    end

    uint_diver #(
        .STEPS (DATA_W),
        .CNT_W ($clog2(DATA_W))
    ) u_diver (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .en        (div_en),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .end_flag  (div_end)
    );

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The parameter list SHALL be: DATA_W, default `datawidth (32), operand/result width.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n SHALL be input, 1 bit, reset, asynchronous and active-low.
REQ-004 Port start SHALL be input, 1 bit, request pulse; it is accepted only in IDLE.
REQ-005 Port op SHALL be input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU; it is sampled with start.
REQ-006 Ports src_a and src_b SHALL be inputs, DATA_W bits each: src_a is the dividend and src_b the divisor; both are sampled with start.
REQ-007 Port flush SHALL be input, 1 bit, pipeline kill that aborts the current operation.
REQ-008 Port busy SHALL be output, 1 bit, high in every state except IDLE; it is the pipeline stall request.
REQ-009 Port done SHALL be output, 1 bit, a single-cycle completion pulse.
REQ-010 Port result SHALL be output, DATA_W bits, the quotient or remainder selected by op; it is held stable until the next accepted start.
REQ-011 Port div_by_zero SHALL be output, 1 bit, asserted with done when the sampled src_b was 0; it is held with result.

Function
REQ-012 The FSM SHALL have the states IDLE, PREP, RUN, POST and DONE.
REQ-013 On start in IDLE, the block SHALL go to PREP and latch op, the sign of src_a, the sign of src_b and the zero-divisor flag.
REQ-014 In PREP, the operands SHALL be converted to magnitudes for DIV and REM (two's-complement negate when the MSB is set), passed unchanged for DIVU and REMU, and loaded into the sub-divider; the next state SHALL be RUN.
REQ-015 In RUN, the sub-divider enable SHALL be held high until its end flag is seen; the next state SHALL be POST, and the enable SHALL drop in the same cycle.
REQ-016 In POST, the block SHALL sign-fix: quotient negated when the operand signs differ, remainder takes the dividend's sign; the fixed value SHALL be registered into result; the next state SHALL be DONE.
REQ-017 In DONE, done SHALL be high for one cycle and the next state SHALL be IDLE.
REQ-018 Latency SHALL be fixed: with DATA_W=32, done SHALL be high exactly 36 cycles after the start-accept edge, independent of operand values (macro off).
REQ-019 For divide-by-zero, the quotient SHALL be all ones (-1 for DIV), the remainder SHALL equal src_a unchanged, and div_by_zero SHALL be 1.
REQ-020 For signed overflow (src_a = 0x80000000, src_b = 0xFFFFFFFF, DIV or REM), the quotient SHALL be 0x80000000 and the remainder 0.
REQ-021 A start that is not in IDLE SHALL be ignored, with no queueing.
REQ-022 A flush in any state SHALL force IDLE on the next edge: done is not asserted, result and div_by_zero keep their previous values, and the sub-divider enable drops immediately.
REQ-023 If start and flush arrive in the same IDLE cycle, flush SHALL win and start SHALL be ignored.

Reset
REQ-024 While rst_n is low, the state SHALL be IDLE and busy, done, div_by_zero and result SHALL all be 0, asynchronously.
REQ-025 If reset arrives mid-operation, the operation SHALL be discarded; after release, the first start SHALL behave as from power-up.

Configuration
REQ-026 The feature macro SHALL be DIV_FASTPATH_EN.
REQ-027 With DIV_FASTPATH_EN defined, a zero divisor or signed overflow SHALL skip RUN (PREP→POST) and give done 3 cycles after start-accept; values SHALL be as in REQ-019/020.
REQ-028 Without DIV_FASTPATH_EN, every operation SHALL take the REQ-018 latency, with values still as in REQ-019/020.

Structure
REQ-029 DATA_W, the op encodings, the FSM state encodings and DIV_STEPS/DIV_STEPS_Log2 SHALL live in the shared defines.v include.
REQ-030 Exactly one sub-module SHALL be instantiated: the existing unsigned iterative divider uint_diver; no second divider SHALL be built.

Verification
REQ-031 The bench SHALL cover DIVU 100/7: done at cycle 36, result 14, div_by_zero 0; with REMU on the same operands, result 2.
REQ-032 The bench SHALL cover DIV -7/2 → result 0xFFFFFFFD (-3), and REM -7/2 → result 0xFFFFFFFF (-1).
REQ-033 The bench SHALL cover DIVU 5/0: result 0xFFFFFFFF, div_by_zero 1, latency 36 (macro off) or 3 (macro on); REM 5/0 → result 5.
REQ-034 The bench SHALL cover DIV 0x80000000/0xFFFFFFFF: result 0x80000000, and REM → result 0.
REQ-035 The bench SHALL cover flush at cycle 10 of a DIVU: no done, busy low on the next cycle, result unchanged; a new start then completes correctly.
REQ-036 The bench SHALL cover a second start at cycle 5 of a DIVU: it is ignored, with a single done at cycle 36 carrying the first operation's result.
